// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O slave: register offsets,
// TCON bit positions and the active-low 7-segment glyph table.
package io_pkg;

  localparam logic [31:0] BASE_DEFAULT = 32'h4000_0000;

  localparam logic [2:0] OFF_TH     = 3'd0;
  localparam logic [2:0] OFF_TL     = 3'd1;
  localparam logic [2:0] OFF_TCON   = 3'd2;
  localparam logic [2:0] OFF_LED    = 3'd3;
  localparam logic [2:0] OFF_SWITCH = 3'd4;
  localparam logic [2:0] OFF_DIGI   = 3'd5;

  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_ST  = 2;

  // Entry n is the {dp,g,f,e,d,c,b,a} pattern for hex digit n; dp is always off.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode hex display.
// Each digit slot lasts SCAN_DIV clocks; disabled digits keep their anode off.
module seg7_scan
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  en,
  output logic [11:0] digi
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    anode;
  logic [3:0]    nibble;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign anode[gi] = ~(en[gi] && (idx_q == 2'(gi)));
    end
  endgenerate

  assign nibble = value[{idx_q, 2'b00} +: 4];
  assign digi   = {anode, hex_to_seg(nibble)};

endmodule

// File: rtl/io_bus_slave.sv
// Peripheral slave on the CPU data bus: reload timer with interrupt, LEDs,
// synchronised switches and a 7-segment display. Reads are combinational.
module io_bus_slave
  import io_pkg::*;
#(
  parameter int          SCAN_DIV = 50000,
  parameter logic [31:0] BASE     = BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  input  logic [7:0]  switch,
  output logic [11:0] digi,
  output logic        irqout
);

  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic        run_q, run_d, ie_q, ie_d, st_q, st_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [15:0] digi_val_q, digi_val_d;
  logic [3:0]  digi_en_q, digi_en_d;
  logic        overflow;
  logic [2:0]  off;
  logic        unused_bits;

  assign off         = addr[4:2];
  assign unused_bits = ^{BASE, addr[31:5], addr[1:0]};

  always_comb begin
    th_d       = th_q;
    tl_d       = tl_q;
    run_d      = run_q;
    ie_d       = ie_q;
    st_d       = st_q;
    led_d      = led_q;
    digi_val_d = digi_val_q;
    digi_en_d  = digi_en_q;
    overflow   = 1'b0;

    if (run_q) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d     = th_q;
        overflow = ie_q;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (wr) begin
      case (off)
        OFF_TH:   th_d = wdata;
        OFF_TL:   tl_d = wdata;
        OFF_TCON: begin
          run_d = wdata[TCON_RUN];
          ie_d  = wdata[TCON_IE];
          st_d  = wdata[TCON_ST];
        end
        OFF_LED:  led_d = wdata[7:0];
        OFF_DIGI: begin
          digi_val_d = wdata[15:0];
          digi_en_d  = wdata[19:16];
        end
        default:  ;
      endcase
    end

    // An overflow in the same cycle as a software clear must not be lost.
    if (overflow) st_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q       <= '0;
      tl_q       <= '0;
      run_q      <= 1'b0;
      ie_q       <= 1'b0;
      st_q       <= 1'b0;
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      digi_val_q <= '0;
      digi_en_q  <= 4'hF;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      run_q      <= run_d;
      ie_q       <= ie_d;
      st_q       <= st_d;
      led_q      <= led_d;
      sw_meta_q  <= switch;
      sw_sync_q  <= sw_meta_q;
      digi_val_q <= digi_val_d;
      digi_en_q  <= digi_en_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFF_TH:     rdata = th_q;
        OFF_TL:     rdata = tl_q;
        OFF_TCON:   rdata = {29'd0, st_q, ie_q, run_q};
        OFF_LED:    rdata = {24'd0, led_q};
        OFF_SWITCH: rdata = {24'd0, sw_sync_q};
        OFF_DIGI:   rdata = {12'd0, digi_en_q, digi_val_q};
        default:    rdata = '0;
      endcase
    end
  end

  assign led    = led_q;
  assign irqout = ie_q & st_q;

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .value (digi_val_q),
    .en    (digi_en_q),
    .digi  (digi)
  );

endmodule

// File: tb/tb_io_bus_slave.sv
// Self-checking bench for io_bus_slave: a behavioural model checked every
// cycle, plus directed reads with hand-computed literal expectations.
module tb_io_bus_slave;

  localparam int          SCAN_DIV = 4;
  localparam logic [31:0] BASE     = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  switch = '0;
  logic [11:0] digi;
  logic        irqout;

  int n_checks = 0;
  int n_fail   = 0;

  io_bus_slave #(.SCAN_DIV(SCAN_DIV), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          started = 0;
  logic [31:0] m_th, m_tl;
  bit          m_run, m_ie, m_st;
  logic [7:0]  m_led;
  logic [7:0]  m_sw_hist [2];
  logic [15:0] m_val;
  logic [3:0]  m_en;
  int          m_cycles;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [31:0] model_read();
    if (!rd) return 32'd0;
    case (int'(addr[4:2]))
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_st, m_ie, m_run};
      3: return {24'd0, m_led};
      4: return {24'd0, m_sw_hist[1]};
      5: return {12'd0, m_en, m_val};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [11:0] model_digi();
    int d;
    logic [3:0] an;
    d  = (m_cycles / SCAN_DIV) % 4;
    an = m_en[d] ? ~(4'b0001 << d) : 4'hF;
    return {an, glyph(m_val[4*d +: 4])};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      m_th = 0; m_tl = 0; m_run = 0; m_ie = 0; m_st = 0; m_led = 0;
      m_sw_hist[0] = 0; m_sw_hist[1] = 0;
      m_val = 0; m_en = 4'hF; m_cycles = 0;
    end else if (started) begin
      logic [31:0] tl_n;
      bit fire;
      fire = 0;
      tl_n = m_tl;
      if (m_run) begin
        if (m_tl == 32'hFFFF_FFFF) begin
          tl_n = m_th;
          fire = m_ie;
        end else begin
          tl_n = m_tl + 1;
        end
      end
      if (wr) begin
        case (int'(addr[4:2]))
          0: m_th = wdata;
          1: tl_n = wdata;
          2: begin m_run = wdata[0]; m_ie = wdata[1]; m_st = wdata[2]; end
          3: m_led = wdata[7:0];
          5: begin m_val = wdata[15:0]; m_en = wdata[19:16]; end
          default: ;
        endcase
      end
      if (fire) m_st = 1;
      m_tl = tl_n;
      m_sw_hist[1] = m_sw_hist[0];
      m_sw_hist[0] = switch;
      m_cycles++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("rdata", rdata, model_read());
      check("led", {24'd0, led}, {24'd0, m_led});
      check("irqout", {31'd0, irqout}, {31'd0, (m_ie && m_st)});
      check("digi", {20'd0, digi}, {20'd0, model_digi()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int off, input logic [31:0] data);
    rd = 0; wr = 1; addr = BASE | (off << 2); wdata = data;
    $display("write off=%0d data=%h", off, data);
    cyc();
    wr = 0;
  endtask

  task automatic chk_read(input int off, input logic [31:0] exp, input string name);
    wr = 0; rd = 1; addr = BASE | (off << 2);
    #1;
    $display("read  off=%0d data=%h", off, rdata);
    check(name, rdata, exp);
    cyc();
    rd = 0;
  endtask

  logic [11:0] slot_exp [4];

  initial begin
    slot_exp[0] = 12'hE99; slot_exp[1] = 12'hDB0;
    slot_exp[2] = 12'hFA4; slot_exp[3] = 12'h7F9;

    // reset
    reset = 1;
    cyc(); cyc();
    reset = 0;
    check("rst_led", {24'd0, led}, 32'h0);
    check("rst_irq", {31'd0, irqout}, 32'h0);
    check("rst_digi", {20'd0, digi}, 32'hEC0);
    check("rst_rdata", rdata, 32'h0);
    chk_read(0, 32'h0, "rst_th");
    chk_read(1, 32'h0, "rst_tl");
    chk_read(2, 32'h0, "rst_tcon");
    chk_read(3, 32'h0, "rst_led_reg");
    chk_read(5, 32'h000F_0000, "rst_digi_reg");

    // timer reload and interrupt
    wr_reg(0, 32'hFFFF_FFFC);
    wr_reg(1, 32'hFFFF_FFFE);
    wr_reg(2, 32'h3);
    chk_read(1, 32'hFFFF_FFFE, "tl_start");
    chk_read(1, 32'hFFFF_FFFF, "tl_max");
    check("irq_set", {31'd0, irqout}, 32'h1);
    chk_read(2, 32'h7, "tcon_status");
    wr_reg(2, 32'h3);
    check("irq_clear", {31'd0, irqout}, 32'h0);

    // software clear colliding with overflow
    cyc();
    wr_reg(2, 32'h3);
    check("irq_collide", {31'd0, irqout}, 32'h1);
    chk_read(2, 32'h7, "tcon_collide");
    chk_read(1, 32'hFFFF_FFFD, "tl_after_reload");

    // bus write to TL wins over counting
    wr_reg(1, 32'h5);
    chk_read(1, 32'h5, "tl_write");
    chk_read(1, 32'h6, "tl_count");
    wr_reg(2, 32'h0);
    check("irq_off", {31'd0, irqout}, 32'h0);
    chk_read(1, 32'h8, "tl_hold0");
    chk_read(1, 32'h8, "tl_hold1");

    // bus map
    wr_reg(3, 32'hFFFF_FFA5);
    check("led_a5", {24'd0, led}, 32'hA5);
    chk_read(3, 32'hA5, "led_reg");
    chk_read(6, 32'h0, "unmapped6");
    chk_read(7, 32'h0, "unmapped7");
    wr_reg(4, 32'hFF);
    chk_read(4, 32'h0, "switch_ro");
    rd = 0; addr = BASE | (3 << 2);
    #1;
    check("rd_low", rdata, 32'h0);

    // switch synchroniser
    switch = 8'h3C;
    chk_read(4, 32'h00, "sw_edge0");
    chk_read(4, 32'h00, "sw_edge1");
    chk_read(4, 32'h3C, "sw_edge2");

    // reset beats a simultaneous write
    reset = 1; wr = 1; addr = BASE | (3 << 2); wdata = 32'hFF;
    cyc();
    reset = 0; wr = 0;
    check("rst_prio_led", {24'd0, led}, 32'h0);
    check("rst_prio_digi", {20'd0, digi}, 32'hEC0);

    // display scan: first post-reset cycle writes DIGI
    wr_reg(5, 32'h000B_1234);
    for (int k = 1; k <= 18; k++) begin
      check($sformatf("scan_k%0d", k), {20'd0, digi}, {20'd0, slot_exp[(k / SCAN_DIV) % 4]});
      cyc();
    end
    chk_read(5, 32'h000B_1234, "digi_reg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
